// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller/scheduler: register map,
// service state encoding and the claim-word layout.
// Address decode helper compares word addresses only (addr[1:0] ignored).
package intc_pkg;

   localparam logic [31:0] PEND_OFF  = 32'h0;
   localparam logic [31:0] MASK_OFF  = 32'h4;
   localparam logic [31:0] EDGE_OFF  = 32'h8;
   localparam logic [31:0] CLAIM_OFF = 32'hC;

   localparam int CLAIM_VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // True when addr selects the word at base+off
   function automatic logic reg_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] off);
      logic [31:0] a;
      a = base + off;
      return addr[31:2] == a[31:2];
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder: {vld, id} for the first set request bit.
// Latency: combinational.
// Backpressure: none.
module intc_prio_enc #(
   parameter int N = 6
) (
   input  logic [N-1:0] req,
   output logic         vld,
   output logic [4:0]   id
);

   // Scan from the top so the lowest set index is the last one written
   always_comb begin
      vld = 1'b0;
      id  = 5'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            id  = 5'(i);
         end
      end
   end

endmodule

// File: rtl/intc_sched.sv
// Interrupt controller/scheduler: pending latch, mask, edge/level mode, claim/EOI serialisation.
// Latency: src_irq -> PEND/irq_vec 1 cycle (3 cycles with INTC_SYNC_EN synchroniser); rdata combinational.
// Backpressure: none; every bus access completes in the cycle it is presented.
module intc_sched
   import intc_pkg::*;
#(
   parameter int          NUM_SRC   = 6,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic [31:0]        addr,
   input  logic               we,
   input  logic               re,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic [NUM_SRC-1:0] irq_vec
);

   logic [NUM_SRC-1:0] s;
   logic [NUM_SRC-1:0] prev;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] pend_nxt;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] edge_mode;
   logic [NUM_SRC-1:0] act;
   state_t             state;
   logic [4:0]         cur_id;

   logic               hit_pend;
   logic               hit_mask;
   logic               hit_edge;
   logic               hit_claim;
   logic               enc_vld;
   logic [4:0]         enc_id;
   logic               w1c;
   logic               claim_fire;
   logic               eoi;

   // Byte-lane bits of addr and the upper write-data bits carry no meaning here
   logic               unused_bits;
   assign unused_bits = ^{addr[1:0], wdata};

   assign hit_pend  = reg_hit(addr, BASE_ADDR, PEND_OFF);
   assign hit_mask  = reg_hit(addr, BASE_ADDR, MASK_OFF);
   assign hit_edge  = reg_hit(addr, BASE_ADDR, EDGE_OFF);
   assign hit_claim = reg_hit(addr, BASE_ADDR, CLAIM_OFF);

`ifdef INTC_SYNC_EN
   logic [NUM_SRC-1:0] sync1;
   logic [NUM_SRC-1:0] sync2;

   // Two-flop synchroniser for asynchronous source lines
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= src_irq;
         sync2 <= sync1;
      end
   end

   assign s = sync2;
`else
   assign s = src_irq;
`endif

   // Active requests: pending and enabled
   assign act = pend & mask;

   intc_prio_enc #(.N(NUM_SRC)) u_prio (
      .req (act),
      .vld (enc_vld),
      .id  (enc_id)
   );

   assign w1c        = we & hit_pend;
   assign claim_fire = re & hit_claim & (state == PENDING) & enc_vld;
   assign eoi        = we & hit_claim & (state == SERVICE) & (wdata[4:0] == cur_id);

   // Next pending: level bits track the sample; edge bits set on a rise, which beats any clear
   always_comb begin
      pend_nxt = pend;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!edge_mode[i]) begin
            pend_nxt[i] = s[i];
         end else begin
            pend_nxt[i] = (s[i] & ~prev[i]) |
                          (pend[i] & ~(w1c & wdata[i]) & ~(claim_fire & (enc_id == 5'(i))));
         end
      end
   end

   // Pending, previous sample and configuration registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev      <= '0;
         pend      <= '0;
         mask      <= '0;
         edge_mode <= '0;
      end else begin
         prev <= s;
         pend <= pend_nxt;
         if (we && hit_mask) mask <= wdata[NUM_SRC-1:0];
         if (we && hit_edge) edge_mode <= wdata[NUM_SRC-1:0];
      end
   end

   // Service FSM: one interrupt in service at a time, released by a matching EOI
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cur_id <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|act) state <= PENDING;
            end
            PENDING: begin
               if (claim_fire) begin
                  state  <= SERVICE;
                  cur_id <= enc_id;
               end else if (!(|act)) begin
                  state <= IDLE;
               end
            end
            SERVICE: begin
               if (eoi) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Combinational read mux; the claim word depends on the service state
   always_comb begin
      rdata = '0;
      if (hit_pend) begin
         rdata[NUM_SRC-1:0] = pend;
      end else if (hit_mask) begin
         rdata[NUM_SRC-1:0] = mask;
      end else if (hit_edge) begin
         rdata[NUM_SRC-1:0] = edge_mode;
      end else if (hit_claim) begin
         if (state == PENDING && enc_vld) begin
            rdata[CLAIM_VALID_BIT] = 1'b1;
            rdata[4:0]             = enc_id;
         end else if (state == SERVICE) begin
            rdata[CLAIM_VALID_BIT] = 1'b1;
            rdata[4:0]             = cur_id;
         end
      end
   end

   // No nesting: the CPU sees nothing while an interrupt is in service
   assign irq_vec = (state == SERVICE) ? '0 : act;

endmodule

// File: tb/tb_intc_sched.sv
module tb_intc_sched;

   localparam int          N    = 6;
   localparam logic [31:0] BASE = 32'h0000_7F30;
`ifdef INTC_SYNC_EN
   localparam int          LAT  = 3;
`else
   localparam int          LAT  = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  src_irq;
   logic [31:0]   addr;
   logic          we;
   logic          re;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [N-1:0]  irq_vec;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   intc_sched #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .src_irq (src_irq),
      .addr    (addr),
      .we      (we),
      .re      (re),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq_vec (irq_vec)
   );

   // ---------------- behavioural model ----------------
   logic [N-1:0] m_pend, m_mask, m_edge, m_prev, m_sy1, m_sy2;
   int           m_state;   // 0 idle, 1 waiting for claim, 2 in service
   int           m_cur;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int reg_index(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off < 32'd16) return int'(off >> 2);
      return -1;
   endfunction

   function automatic logic [31:0] exp_rdata();
      int id;
      id = lowest(m_pend & m_mask);
      case (reg_index(addr))
         0: return 32'(m_pend);
         1: return 32'(m_mask);
         2: return 32'(m_edge);
         3: begin
            if (m_state == 1 && id >= 0) return 32'h8000_0000 | 32'(id);
            if (m_state == 2)            return 32'h8000_0000 | 32'(m_cur);
            return 32'h0;
         end
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [N-1:0] exp_irq();
      if (m_state == 2) return '0;
      return m_pend & m_mask;
   endfunction

   always @(posedge clk or negedge reset) begin : model
      logic [N-1:0] s, act, np;
      int           ri, id;
      bit           fire;
      if (!reset) begin
         m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
         m_sy1 = '0; m_sy2 = '0; m_state = 0; m_cur = 0;
      end else begin
         ri   = reg_index(addr);
         act  = m_pend & m_mask;
         id   = lowest(act);
         fire = re && ri == 3 && m_state == 1 && id >= 0;
`ifdef INTC_SYNC_EN
         s = m_sy2; m_sy2 = m_sy1; m_sy1 = src_irq;
`else
         s = src_irq;
`endif
         for (int i = 0; i < N; i++) begin
            if (!m_edge[i])                             np[i] = s[i];
            else if (s[i] && !m_prev[i])                np[i] = 1'b1;
            else if ((we && ri == 0 && wdata[i]) || (fire && id == i)) np[i] = 1'b0;
            else                                        np[i] = m_pend[i];
         end
         case (m_state)
            0: if (act != 0) m_state = 1;
            1: if (fire) begin m_state = 2; m_cur = id; end
               else if (act == 0) m_state = 0;
            2: if (we && ri == 3 && wdata[4:0] == 5'(m_cur)) m_state = 0;
            default: m_state = 0;
         endcase
         if (we && ri == 1) m_mask = wdata[N-1:0];
         if (we && ri == 2) m_edge = wdata[N-1:0];
         m_pend = np;
         m_prev = s;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      check("model_irq_vec", 32'(irq_vec), 32'(exp_irq()));
      check("model_rdata", rdata, exp_rdata());
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      addr = BASE + off; wdata = d; we = 1'b1;
      tick();
      we = 1'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic rd_chk(input logic [31:0] off, input logic r, input logic [31:0] e, input string nm);
      addr = BASE + off; re = r;
      #2 check(nm, rdata, e);
      tick();
      re = 1'b0; addr = 32'h0;
   endtask

   task automatic peek_irq(input logic [N-1:0] e, input string nm);
      #2 check(nm, 32'(irq_vec), 32'(e));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b0; src_irq = 6'h3F; addr = 32'h0; we = 1'b0; re = 1'b0; wdata = 32'h0;
      tick(2);

      // Reset: everything reads 0 even with all sources high
      peek_irq(6'h00, "rst_irq");
      rd_chk(32'h0, 1'b1, 32'h0, "rst_pend");
      rd_chk(32'h4, 1'b1, 32'h0, "rst_mask");
      rd_chk(32'h8, 1'b1, 32'h0, "rst_edge");
      rd_chk(32'hC, 1'b1, 32'h0, "rst_claim");
      reset = 1'b1;
      rd_chk(32'h0, 1'b0, 32'h0, "rst_rel_pend");
      peek_irq(6'h00, "rst_rel_irq_masked");

      // Edge path with claim and EOI
      src_irq = 6'h00;
      tick(LAT + 1);
      wr(32'h8, 32'h1);
      wr(32'h4, 32'h1);
      src_irq = 6'h01;
      tick();
      src_irq = 6'h00;
      tick(LAT - 1);
      peek_irq(6'h01, "edge_irq");
      tick();
      rd_chk(32'hC, 1'b1, 32'h8000_0000, "edge_claim");
      peek_irq(6'h00, "edge_svc_irq");
      wr(32'hC, 32'h0);
      rd_chk(32'hC, 1'b1, 32'h0, "edge_after_eoi");

      // Priority among level sources, EOI id matching
      wr(32'h8, 32'h0);
      src_irq = 6'b000110;
      wr(32'h4, 32'hFFFF_FFFF);
      rd_chk(32'h4, 1'b0, 32'h0000_003F, "mask_upper_bits");
      tick(LAT);
      rd_chk(32'hC, 1'b1, 32'h8000_0001, "prio_claim");
      rd_chk(32'hC, 1'b1, 32'h8000_0001, "prio_svc_claim");
      peek_irq(6'h00, "prio_svc_irq");
      wr(32'hC, 32'h2);
      peek_irq(6'h00, "prio_bad_eoi");
      wr(32'hC, 32'h1);
      peek_irq(6'b000110, "prio_eoi_irq");

      // Level source ignores W1C and follows the line
      wr(32'h4, 32'h2);
      src_irq = 6'b000010;
      tick(LAT);
      wr(32'h0, 32'h2);
      rd_chk(32'h0, 1'b0, 32'h2, "lvl_w1c_ignored");
      src_irq = 6'h00;
      tick(LAT);
      rd_chk(32'h0, 1'b0, 32'h0, "lvl_drop");

      // Rising edge colliding with W1C on bit 3
      wr(32'h4, 32'h0);
      wr(32'h8, 32'h8);
      src_irq = 6'h08;
      tick();
      src_irq = 6'h00;
      tick(LAT);
      src_irq = 6'h08;
      tick(LAT - 1);
      wr(32'h0, 32'h8);
      rd_chk(32'h0, 1'b0, 32'h8, "coll_pend");
      wr(32'h0, 32'h8);
      rd_chk(32'h0, 1'b0, 32'h0, "w1c_clears");
      src_irq = 6'h00;
      tick(LAT);
      src_irq = 6'h08;
      tick(LAT);
      rd_chk(32'hC, 1'b1, 32'h0, "idle_claim");
      rd_chk(32'h0, 1'b0, 32'h8, "idle_claim_noeff");

      // Asynchronous reset while in service
      wr(32'h4, 32'h8);
      tick();
      rd_chk(32'hC, 1'b1, 32'h8000_0003, "svc_claim");
      #2 reset = 1'b0;
      #1 check("midrst_irq", 32'(irq_vec), 32'h0);
      addr = BASE + 32'h4;
      #1 check("midrst_mask", rdata, 32'h0);
      addr = BASE + 32'hC;
      #1 check("midrst_claim", rdata, 32'h0);
      addr = 32'h0;
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;

      // Source-to-vector latency
      src_irq = 6'h00;
      wr(32'h4, 32'h1);
      tick(LAT);
      src_irq = 6'h01;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         peek_irq((k == LAT) ? 6'h01 : 6'h00, "latency");
      end
      src_irq = 6'h00;
      tick(LAT + 2);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int sel;
         sel = int'($urandom_range(0, 11));
         if ($urandom_range(0, 3) == 0) src_irq = 6'($urandom);
         we = 1'b0; re = 1'b0; wdata = $urandom;
         addr = BASE + 32'($urandom_range(0, 3));
         case (sel)
            0, 1, 2: begin addr = addr + 32'hC; re = 1'b1; end
            3, 4:    begin addr = addr + 32'hC; we = 1'b1; wdata = 32'($urandom_range(0, 6)); end
            5:       begin we = 1'b1; end
            6:       begin addr = addr + 32'h4; we = 1'b1; end
            7:       begin addr = addr + 32'h8; we = $urandom_range(0, 3) == 0; end
            8:       begin addr = addr + 32'h10; we = 1'b1; re = 1'b1; end
            9:       begin addr = BASE - 32'h4; we = 1'b1; re = 1'b1; end
            10:      begin addr = addr + 32'($urandom_range(0, 3) * 4); end
            default: begin addr = 32'h0; end
         endcase
         tick();
      end
      we = 1'b0; re = 1'b0; addr = 32'h0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/intc_sched.md
Name: intc_sched

Overview:
- Interrupt controller/scheduler between the interrupt sources (timer0 IRQ, timer1 IRQ, external interrupt, spare lines) and the CPU's 6-bit HWInt input (INTcode).
- Latches sources as pending, applies mask and edge/level mode, and presents a gated vector to the CPU.
- Serialises service with a claim/EOI handshake.
- Memory-mapped on the bridge data bus: decoded like a timer, with a combinational read path.

Parameters:
- NUM_SRC, 6, number of interrupt sources (max 31).
- BASE_ADDR, 32'h0000_7F30, word-aligned base of the 4-register window.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- src_irq  in  NUM_SRC  raw source lines; bit0 has the highest priority.
- addr  in  32  CPU data address (word-decoded on addr[31:2]).
- we  in  1  write strobe, already qualified by the bridge.
- re  in  1  read strobe; claim side effects occur only when re=1.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr.
- irq_vec  out  NUM_SRC  gated interrupt vector, drives CPU INTcode.

Behaviour:
- Registers, by offset from BASE_ADDR:
  - +0 PEND: read; write-1-to-clear (W1C) on edge-mode bits only.
  - +4 MASK: read/write; 1 = enabled.
  - +8 EDGE: read/write; 1 = rising-edge mode, 0 = level mode.
  - +C CLAIM: read = claim; write = EOI.
- Unused upper bits read 0. Addresses outside the window: rdata=0, no effect.
- Reset (async, active-low) values: PEND=0, MASK=0, EDGE=0, prev-sample=0, state=IDLE, cur_id=0. Therefore irq_vec=0 and rdata=0 during reset.
- Sampling: s = src_irq, registered once (see Optional Feature). prev = s delayed one cycle.
- Pending update:
  - Edge bit sets PEND[i] when s[i] & ~prev[i].
  - Level bit: PEND[i] follows s[i] each cycle; W1C and claim have no effect on it.
- Latency: src_irq change -> PEND change 1 cycle later -> irq_vec in the same cycle as the PEND change.
- FSM states: IDLE, PENDING, SERVICE.
  - IDLE -> PENDING when |(PEND & MASK).
  - PENDING -> IDLE when (PEND & MASK) becomes 0 before a claim.
  - PENDING + claim read -> SERVICE:
    - cur_id = lowest index i with PEND[i] & MASK[i].
    - rdata = {1'b1, 26'b0, cur_id[4:0]} in that cycle.
    - At the clock edge, an edge-mode PEND[cur_id] is cleared.
  - SERVICE + write to CLAIM with wdata[4:0]==cur_id -> IDLE (EOI). A mismatched id is ignored; state stays SERVICE.
- irq_vec = PEND & MASK in IDLE/PENDING; irq_vec = 0 in SERVICE (no nesting).
- Claim read side-effect rules:
  - In IDLE: returns 0, no side effect.
  - In SERVICE: returns {1, cur_id}, no side effect.
  - With re=0: no side effect.
- Simultaneous events:
  - A new rising edge in the same cycle as W1C or claim-clear on that bit -> bit ends set.
  - MASK write and claim in the same cycle -> claim uses the pre-write MASK.
- Writes to PEND bits in level mode, or to bits >= NUM_SRC, are ignored.
- EDGE change on a bit takes effect from the next cycle; that bit's PEND is not cleared.

Optional Feature:
- Macro INTC_SYNC_EN.
- Defined: src_irq passes a 2-flop synchroniser before s. Source-to-PEND latency becomes 3 cycles.
- Undefined: single register stage, 1-cycle latency as above.

Decomposition:
- Shared package intc_pkg:
  - register offsets PEND_OFF=0, MASK_OFF=4, EDGE_OFF=8, CLAIM_OFF=12;
  - state enum (IDLE, PENDING, SERVICE);
  - CLAIM_VALID_BIT=31.
- One natural sub-module, intc_prio_enc: a combinational lowest-index priority encoder producing {valid, id[4:0]} from NUM_SRC bits.

Test Plan:
- Reset: reset=0 with src_irq=6'h3F -> irq_vec=0, all register reads 0. Release reset -> PEND still 0 while MASK=0.
- Edge path: EDGE=6'h01, MASK=6'h01, pulse src_irq[0] for one cycle -> PEND=1 and irq_vec=6'h01 one cycle later. Claim read -> rdata=32'h8000_0000, irq_vec=0 next cycle. EOI write 0 -> IDLE.
- Priority: level mode, MASK=6'h3F, src_irq=6'b000110 -> claim returns 32'h8000_0001. Claim while in SERVICE returns the same value. EOI with id 2 is ignored; EOI with id 1 -> irq_vec=6'b000110 again.
- Level source: EDGE=0, MASK=6'h02, src_irq[1] held high -> W1C of PEND bit1 leaves PEND=2. Drop src_irq[1] -> PEND=0 next cycle.
- Collision: edge bit3, rising edge in the same cycle as W1C 32'h8 -> PEND[3] remains 1. Claim in IDLE -> rdata=0, state unchanged.
- Mid-operation reset: reset asserted while in SERVICE -> state IDLE, PEND/MASK=0 immediately (async). With INTC_SYNC_EN, verify 3-cycle source latency.
